// File: rtl/lfsr_checker.sv
// Bit-serial PRBS checker for a 4-bit XNOR LFSR stream (next = ~(s[3]^s[2]), LSB shift-in).
// Self-synchronises, declares lock, then free-runs its own LFSR to count bit errors.
// Optional macro LFSR_CHK_LOCKUP_DET_EN: blocks locking on an all-ones stream and
// drives the lockup flag; without it lockup_o is tied low.
module lfsr_checker #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned TAP_A      = 3,
    parameter int unsigned TAP_B      = 2,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned ERR_WINDOW = 16,
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    input  logic             clear_cnt_i,
    output logic             locked_o,
    output logic             bit_err_o,
    output logic             lock_lost_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic             lockup_o
);

    localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W   = $clog2(ERR_WINDOW + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);
    localparam logic [WIN_W-1:0]   WIN_FULL   = WIN_W'(ERR_WINDOW);
    localparam logic [WIN_W-1:0]   WIN_THRESH = WIN_W'(ERR_THRESH);

    typedef enum logic [0:0] {
        StSearch,
        StLocked
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]   win_err_q, win_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic               locked_q, locked_d;
    logic               bit_err_q, bit_err_d;
    logic               lock_lost_q, lock_lost_d;

    logic               pred;
    logic               mismatch;
    logic               hold_match;
    logic [WIN_W-1:0]   win_cnt_inc;
    logic [WIN_W-1:0]   win_err_inc;

`ifdef LFSR_CHK_LOCKUP_DET_EN
    logic [MATCH_W-1:0] ones_q, ones_d;
    logic               lockup_q, lockup_d;
`endif

    // Next-state logic: prediction, search/lock FSM, window monitor and counters
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        locked_d    = locked_q;
        bit_err_d   = 1'b0;
        lock_lost_d = 1'b0;
        win_cnt_inc = win_cnt_q + WIN_W'(1);
        win_err_inc = win_err_q;

        pred     = ~(sr_q[TAP_A] ^ sr_q[TAP_B]);
        mismatch = (in_bit_i != pred);

`ifdef LFSR_CHK_LOCKUP_DET_EN
        ones_d     = ones_q;
        // An all-ones register fed a 1 predicts itself forever; refuse to count it.
        hold_match = (&sr_q) & in_bit_i;
`else
        hold_match = 1'b0;
`endif

        if (in_valid_i) begin
            unique case (state_q)
                StSearch: begin
                    sr_d = {sr_q[WIDTH-2:0], in_bit_i};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else begin
`ifdef LFSR_CHK_LOCKUP_DET_EN
                        if (hold_match) begin
                            ones_d = (ones_q == MATCH_LOCK) ? ones_q : ones_q + MATCH_W'(1);
                        end else begin
                            ones_d = '0;
                        end
`endif
                        if (mismatch) begin
                            match_d = '0;
                        end else if (!hold_match) begin
                            match_d = match_q + MATCH_W'(1);
                            if (match_d == MATCH_LOCK) begin
                                state_d   = StLocked;
                                locked_d  = 1'b1;
                                win_cnt_d = '0;
                                win_err_d = '0;
                            end
                        end
                    end
                end
                StLocked: begin
                    // Free-run: the local LFSR ignores the received bit once locked.
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                    if (mismatch) begin
                        bit_err_d   = 1'b1;
                        win_err_inc = win_err_q + WIN_W'(1);
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                    if (win_cnt_inc == WIN_FULL) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (win_err_inc >= WIN_THRESH) begin
                            state_d     = StSearch;
                            locked_d    = 1'b0;
                            lock_lost_d = 1'b1;
                            fill_d      = '0;
                            match_d     = '0;
                        end
                    end else begin
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end
`ifdef LFSR_CHK_LOCKUP_DET_EN
                    ones_d = '0;
`endif
                end
                default: ;
            endcase
        end

        // Clear wins over any same-cycle increment; FSM and window are untouched.
        if (clear_cnt_i) begin
            err_count_d = '0;
            bit_count_d = '0;
        end

`ifdef LFSR_CHK_LOCKUP_DET_EN
        lockup_d = (state_d == StSearch) && (ones_d == MATCH_LOCK);
`endif
    end

    // State and registered outputs, asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSearch;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            bit_count_q <= '0;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            lock_lost_q <= 1'b0;
`ifdef LFSR_CHK_LOCKUP_DET_EN
            ones_q      <= '0;
            lockup_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
            lock_lost_q <= lock_lost_d;
`ifdef LFSR_CHK_LOCKUP_DET_EN
            ones_q      <= ones_d;
            lockup_q    <= lockup_d;
`endif
        end
    end

    assign locked_o    = locked_q;
    assign bit_err_o   = bit_err_q;
    assign lock_lost_o = lock_lost_q;
    assign err_count_o = err_count_q;
    assign bit_count_o = bit_count_q;
`ifdef LFSR_CHK_LOCKUP_DET_EN
    assign lockup_o    = lockup_q;
`else
    assign lockup_o    = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock-in, single errors, loss of lock, valid gaps,
// counter clear/saturation and the all-ones stream (both macro settings).
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        clear_cnt;

    logic        locked, bit_err, lock_lost, lockup;
    logic [15:0] err_count, bit_count;
    logic        s_locked, s_bit_err, s_lock_lost, s_lockup;
    logic [2:0]  s_err_count, s_bit_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  gen;

    lfsr_checker dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_bit_i    (in_bit),
        .clear_cnt_i (clear_cnt),
        .locked_o    (locked),
        .bit_err_o   (bit_err),
        .lock_lost_o (lock_lost),
        .err_count_o (err_count),
        .bit_count_o (bit_count),
        .lockup_o    (lockup)
    );

    // Narrow-counter instance on the same inputs, used to reach saturation quickly
    lfsr_checker #(.CNT_W(3)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_bit_i    (in_bit),
        .clear_cnt_i (clear_cnt),
        .locked_o    (s_locked),
        .bit_err_o   (s_bit_err),
        .lock_lost_o (s_lock_lost),
        .err_count_o (s_err_count),
        .bit_count_o (s_bit_count),
        .lockup_o    (s_lockup)
    );

    always #5 clk = ~clk;

    function automatic logic gen_next(input logic [3:0] g);
        return ~(g[3] ^ g[2]);
    endfunction

    // One valid generator bit, optionally inverted on the line
    task automatic send(input logic flip);
        logic b;
        b        = gen_next(gen);
        in_valid = 1'b1;
        in_bit   = b ^ flip;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        gen      = {gen[2:0], b};
    endtask

    // Invalid cycle driving the wrong bit, which must be ignored
    task automatic idle();
        in_valid = 1'b0;
        in_bit   = ~gen_next(gen);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;
        gen       = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
        #1;
        n_checks++;
        if ({locked, bit_err, lock_lost, lockup} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {locked, bit_err, lock_lost, lockup});
        end
        n_checks++;
        if (err_count !== 16'd0 || bit_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts: err=%0d bit=%0d expected 0 0", err_count, bit_count);
        end
        do_reset();
    endtask

    task automatic test_lock();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            send(1'b0);
            if (bit_err) pulses++;
            if (i == 11) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_early: locked=%b after 11 bits expected 0", locked);
                end
            end
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_at_12: locked=%b expected 1", locked);
        end
        for (int i = 0; i < 20; i++) begin
            send(1'b0);
            if (bit_err) pulses++;
        end
        n_checks++;
        if (pulses != 0 || err_count !== 16'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_stream: pulses=%0d err=%0d locked=%b expected 0 0 1",
                     pulses, err_count, locked);
        end
        n_checks++;
        if (bit_count !== 16'd20) begin
            n_fail++;
            $display("FAIL clean_bit_count: got %0d expected 20", bit_count);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        repeat (12) send(1'b0);
        repeat (3) send(1'b0);
        send(1'b1);
        n_checks++;
        if ({bit_err, locked} !== 2'b11 || err_count !== 16'd1 || bit_count !== 16'd4) begin
            n_fail++;
            $display("FAIL single_err: bit_err=%b locked=%b err=%0d bits=%0d expected 1 1 1 4",
                     bit_err, locked, err_count, bit_count);
        end
        send(1'b0);
        n_checks++;
        if (bit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err_pulse: bit_err=%b expected 0", bit_err);
        end
        repeat (15) send(1'b0);
        n_checks++;
        if (locked !== 1'b1 || err_count !== 16'd1 || bit_count !== 16'd20) begin
            n_fail++;
            $display("FAIL single_err_after: locked=%b err=%0d bits=%0d expected 1 1 20",
                     locked, err_count, bit_count);
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        repeat (12) send(1'b0);
        for (int i = 1; i <= 16; i++) begin
            send(i == 2 || i == 5 || i == 9 || i == 13);
            if (i == 13) begin
                n_checks++;
                if (bit_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL loss_bit_err: bit_err=%b expected 1", bit_err);
                end
            end
            if (i == 15) begin
                n_checks++;
                if (locked !== 1'b1 || lock_lost !== 1'b0) begin
                    n_fail++;
                    $display("FAIL loss_early: locked=%b lock_lost=%b expected 1 0",
                             locked, lock_lost);
                end
            end
        end
        n_checks++;
        if (lock_lost !== 1'b1 || locked !== 1'b0 || err_count !== 16'd4 || bit_count !== 16'd16) begin
            n_fail++;
            $display("FAIL loss_close: lost=%b locked=%b err=%0d bits=%0d expected 1 0 4 16",
                     lock_lost, locked, err_count, bit_count);
        end
        send(1'b0);
        n_checks++;
        if (lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_pulse: lock_lost=%b expected 0", lock_lost);
        end
        repeat (10) send(1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_early: locked=%b after 11 bits expected 0", locked);
        end
        send(1'b0);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: locked=%b after 12 bits expected 1", locked);
        end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            send(1'b0);
            if (k == 12) begin
                n_checks++;
                if (locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_lock: locked=%b after 12 valid bits expected 1", locked);
                end
            end
            idle();
            if (k == 11) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_early: locked=%b after 11 valid bits expected 0", locked);
                end
            end
        end
        send(1'b0);
        send(1'b0);
        repeat (3) idle();
        n_checks++;
        if (bit_count !== 16'd2 || locked !== 1'b1 || bit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_hold: bits=%0d locked=%b bit_err=%b expected 2 1 0",
                     bit_count, locked, bit_err);
        end
    endtask

    task automatic test_clear_cnt();
        do_reset();
        repeat (12) send(1'b0);
        repeat (2) send(1'b0);
        clear_cnt = 1'b1;
        send(1'b1);
        clear_cnt = 1'b0;
        n_checks++;
        if (err_count !== 16'd0 || bit_count !== 16'd0 || {bit_err, locked} !== 2'b11) begin
            n_fail++;
            $display("FAIL clear_same_cycle: err=%0d bits=%0d bit_err=%b locked=%b expected 0 0 1 1",
                     err_count, bit_count, bit_err, locked);
        end
        send(1'b1);
        n_checks++;
        if (err_count !== 16'd1 || bit_count !== 16'd1) begin
            n_fail++;
            $display("FAIL clear_resume: err=%0d bits=%0d expected 1 1", err_count, bit_count);
        end
        clear_cnt = 1'b1;
        idle();
        clear_cnt = 1'b0;
        n_checks++;
        if (err_count !== 16'd0 || bit_count !== 16'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_idle: err=%0d bits=%0d locked=%b expected 0 0 1",
                     err_count, bit_count, locked);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (12) send(1'b0);
        for (int w = 0; w < 3; w++) begin
            for (int i = 1; i <= 16; i++) send(i == 3 || i == 8 || i == 14);
        end
        n_checks++;
        if (locked !== 1'b1 || err_count !== 16'd9 || bit_count !== 16'd48) begin
            n_fail++;
            $display("FAIL window_reset: locked=%b err=%0d bits=%0d expected 1 9 48",
                     locked, err_count, bit_count);
        end
        n_checks++;
        if (s_locked !== 1'b1 || s_err_count !== 3'd7 || s_bit_count !== 3'd7) begin
            n_fail++;
            $display("FAIL saturate: locked=%b err=%0d bits=%0d expected 1 7 7",
                     s_locked, s_err_count, s_bit_count);
        end
    endtask

    task automatic test_stuck_ones();
        do_reset();
        in_bit = 1'b1;
        in_valid = 1'b1;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (locked !== 1'b0 || lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_11: locked=%b lockup=%b expected 0 0", locked, lockup);
        end
        @(posedge clk);
        #1;
`ifdef LFSR_CHK_LOCKUP_DET_EN
        n_checks++;
        if (locked !== 1'b0 || lockup !== 1'b1) begin
            n_fail++;
            $display("FAIL ones_12: locked=%b lockup=%b expected 0 1", locked, lockup);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (locked !== 1'b0 || lockup !== 1'b1) begin
            n_fail++;
            $display("FAIL ones_16: locked=%b lockup=%b expected 0 1", locked, lockup);
        end
        in_bit = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_break: lockup=%b expected 0", lockup);
        end
`else
        n_checks++;
        if (locked !== 1'b1 || lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_12: locked=%b lockup=%b expected 1 0", locked, lockup);
        end
`endif
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (14) send(1'b0);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (locked !== 1'b0 || bit_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: locked=%b bits=%0d expected 0 0", locked, bit_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen = 4'b0000;
        repeat (11) send(1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_relock_early: locked=%b expected 0", locked);
        end
        send(1'b0);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_relock: locked=%b expected 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_lock_loss();
        test_valid_gaps();
        test_clear_cnt();
        test_saturation();
        test_stuck_ones();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
